wb_stream_adapter: RTL and testbench
====================================

WB_STREAM_ADAPTER -- requirements
Module: wb_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream/data width; fixed at 32 to match Wishbone.
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, range 2..16.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, register block base; 16-byte aligned.
REQ-004 SHALL have ports exactly as follows:
  wb_clk_i  in  1  sole clock, rising edge
  wb_rst_i  in  1  reset, asynchronous, active-high
  wbs_stb_i in  1  Wishbone strobe
  wbs_cyc_i in  1  Wishbone cycle
  wbs_we_i  in  1  Wishbone write enable
  wbs_sel_i in  4  byte select; only CTRL uses it
  wbs_dat_i in  32 write data
  wbs_adr_i in  32 byte address
  wbs_ack_o out 1  Wishbone acknowledge
  wbs_dat_o out 32 read data
  m_valid_o out 1  TX stream valid, toward the compute core
  m_data_o  out 32 TX stream data
  m_ready_i in  1  TX stream ready
  s_valid_i in  1  RX stream valid, from the compute core
  s_data_i  in  32 RX stream data
  s_ready_o out 1  RX stream ready

Function
REQ-005 SHALL decode a request when wbs_stb_i & wbs_cyc_i & adr[31:4]==BASE_ADDR[31:4] & !wbs_ack_o. Offset is adr[3:2].
REQ-006 SHALL assert wbs_ack_o for exactly one cycle, on the cycle after the decoded request. No back-to-back acks. A non-matching address gets no ack and has no side effect.
REQ-007 SHALL register wbs_dat_o together with ack. Value is 0 when no ack, and 0 on any acked write.
REQ-008 Register 0x0 TXDATA, write: pushes wbs_dat_i into the TX FIFO. If TX is full at the start of that cycle, the data is dropped and OVF is set. Reads return 0.
REQ-009 Register 0x4 RXDATA, read: returns the RX head and pops it. If RX is empty, returns 0 and sets UNF. Writes are ignored.
REQ-010 Register 0x8 STATUS, read-only:
  bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty
  bit4 OVF, bit5 UNF
  [12:8] tx_count, [20:16] rx_count
  all other bits 0
REQ-011 Register 0xC CTRL, write, effective only if wbs_sel_i[0]:
  bit0 = 1 clears OVF and UNF
  bit1 = 1 flushes both FIFOs (pointers and counts to 0)
  reads return 0
REQ-012 Push and pop SHALL take effect on the ack edge of the access, i.e. one cycle after the request.
REQ-013 SHALL drive m_valid_o = !tx_empty and m_data_o = TX head, combinationally from FIFO state. A pop occurs on m_valid_o & m_ready_i.
REQ-014 SHALL drive s_ready_o = !rx_full. A push occurs on s_valid_i & s_ready_o.
REQ-015 Simultaneous push and pop on the same FIFO, when non-empty and non-full, SHALL leave the count unchanged and preserve order.
REQ-016 Flush SHALL win over any same-cycle stream push/pop or WB push/pop. Those transfers are discarded. OVF/UNF are unchanged by flush.
REQ-017 Pointers SHALL wrap modulo DEPTH. Count range is 0..DEPTH.
REQ-018 OVF and UNF are sticky. A set and a clear in the same cycle SHALL resolve to clear.

Reset
REQ-019 Asserting wb_rst_i SHALL asynchronously force:
  wbs_ack_o=0, wbs_dat_o=0
  both FIFOs empty (m_valid_o=0, s_ready_o=1)
  OVF=0, UNF=0
REQ-020 Reset mid-transaction SHALL abandon the access with no ack after release. FIFO storage contents need not be reset.

Structure
REQ-021 Register offsets, STATUS/CTRL bit positions and the count-field width SHALL live in shared package teras_bridge_pkg.
REQ-022 A single parameterised sub-module, sync_fifo, SHALL be instantiated twice (TX and RX). It has push/pop/full/empty/count and a combinational head.

Verification
REQ-023 Bench SHALL cover:
- Write 0x11,0x22,0x33 to TXDATA with m_ready_i=0 -> STATUS tx_count=3; then m_ready_i=1 -> m_data_o 0x11,0x22,0x33 on consecutive cycles, then m_valid_o=0.
- 9 TXDATA writes with DEPTH=8 and m_ready_i=0 -> all 9 acked, tx_full=1, OVF=1, drained data = first 8 words only.
- Stream in 0xA5 and 0x5A -> RXDATA reads return 0xA5 then 0x5A; a third read returns 0 with UNF=1; CTRL write 0x1 with sel=0xF -> OVF=UNF=0.
- RX full and RXDATA read in the same cycle as s_valid_i -> rx_count stays 8, order intact.
- CTRL 0x2 while both FIFOs hold data -> both empty next cycle; a coincident stream push is discarded.
- wb_rst_i pulsed with a request pending -> no ack, all outputs at reset values, STATUS=0x0000_000A after release.

Source files
------------

// File: rtl/teras_bridge_pkg.sv
// Shared register map and status layout for the Wishbone/stream adapter.
// Offsets, bit positions and count width used by RTL and software alike.
package teras_bridge_pkg;

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_RXDATA = 2'd1,
    OFF_STATUS = 2'd2,
    OFF_CTRL   = 2'd3
  } reg_off_e;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_RX_EMPTY = 3;
  localparam int unsigned ST_OVF      = 4;
  localparam int unsigned ST_UNF      = 5;
  localparam int unsigned ST_TX_CNT   = 8;
  localparam int unsigned ST_RX_CNT   = 16;

  localparam int unsigned CTRL_CLR    = 0;
  localparam int unsigned CTRL_FLUSH  = 1;

  typedef struct packed {
    logic             tx_full;
    logic             tx_empty;
    logic             rx_full;
    logic             rx_empty;
    logic             ovf;
    logic             unf;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;
  } status_t;

  function automatic logic [31:0] pack_status(status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_TX_FULL]  = s.tx_full;
    w[ST_TX_EMPTY] = s.tx_empty;
    w[ST_RX_FULL]  = s.rx_full;
    w[ST_RX_EMPTY] = s.rx_empty;
    w[ST_OVF]      = s.ovf;
    w[ST_UNF]      = s.unf;
    w[ST_TX_CNT +: CNT_W] = s.tx_cnt;
    w[ST_RX_CNT +: CNT_W] = s.rx_cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head and flush.
// Push is ignored when full, pop when empty; flush beats both.
module sync_fifo
  import teras_bridge_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [DW-1:0]    data_i,
  input  logic             pop_i,
  output logic [DW-1:0]    head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/wb_stream_adapter.sv
// Wishbone slave exposing a TX and an RX stream FIFO to software.
// Accesses commit on the ack edge; read data is registered with ack.
module wb_stream_adapter
  import teras_bridge_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        req, wr_req, rd_req;
  reg_off_e    off;
  logic        tx_push, rx_pop, ctrl_wr;
  logic        flush, clr, ovf_set, unf_set;

  logic              tx_full, tx_empty;
  logic              rx_full, rx_empty;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic [DATA_W-1:0] tx_head, rx_head;
  status_t           st;

  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i[3:1], wbs_adr_i[1:0]};

  assign off    = reg_off_e'(wbs_adr_i[3:2]);
  assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q &
                  (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_req = req & wbs_we_i;
  assign rd_req = req & ~wbs_we_i;

  assign tx_push = wr_req & (off == OFF_TXDATA);
  assign rx_pop  = rd_req & (off == OFF_RXDATA);
  assign ctrl_wr = wr_req & (off == OFF_CTRL) & wbs_sel_i[0];
  assign flush   = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
  assign clr     = ctrl_wr & wbs_dat_i[CTRL_CLR];
  assign ovf_set = tx_push & tx_full;
  assign unf_set = rx_pop & rx_empty;

  assign m_valid_o = ~tx_empty;
  assign m_data_o  = tx_head;
  assign s_ready_o = ~rx_full;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  assign st = '{
    tx_full:  tx_full,
    tx_empty: tx_empty,
    rx_full:  rx_full,
    rx_empty: rx_empty,
    ovf:      ovf_q,
    unf:      unf_q,
    tx_cnt:   tx_cnt,
    rx_cnt:   rx_cnt
  };

  sync_fifo #(
    .DW    (DATA_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (flush),
    .push_i  (tx_push),
    .data_i  (wbs_dat_i),
    .pop_i   (m_valid_o & m_ready_i),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt)
  );

  sync_fifo #(
    .DW    (DATA_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (flush),
    .push_i  (s_valid_i & s_ready_o),
    .data_i  (s_data_i),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt)
  );

  // Read data sampled in the request cycle, returned with ack
  always_comb begin
    dat_d = '0;
    if (rd_req) begin
      unique case (off)
        OFF_RXDATA: dat_d = rx_empty ? '0 : rx_head;
        OFF_STATUS: dat_d = pack_status(st);
        default:    dat_d = '0;
      endcase
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set
  always_comb begin
    ack_d = req;
    ovf_d = ovf_q | ovf_set;
    unf_d = unf_q | unf_set;
    if (clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // Bus response and flag registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_wb_stream_adapter.sv
// Bench for wb_stream_adapter: queue-based reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_wb_stream_adapter;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [27:0] BASE_HI = BASE[31:4];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = '0, adr = '0;
  logic        ack, mv, sr;
  logic [31:0] rdat, md;

  logic        d_sv = 1'b0, d_mr = 1'b0;
  logic [31:0] d_sd = '0;
  logic        r_sv = 1'b0, r_mr = 1'b0;
  logic [31:0] r_sd = '0;
  logic        rand_en = 1'b0;
  int          mr_pct = 25;
  logic        sv, mr;
  logic [31:0] sd;

  assign sv = rand_en ? r_sv : d_sv;
  assign mr = rand_en ? r_mr : d_mr;
  assign sd = rand_en ? r_sd : d_sd;

  wb_stream_adapter #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (wdat),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .m_valid_o (mv),
    .m_data_o  (md),
    .m_ready_i (mr),
    .s_valid_i (sv),
    .s_data_i  (sd),
    .s_ready_o (sr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, one bus access per ack
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic        m_ack = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  logic [31:0] m_dat = '0;
  logic        h_hit, h_flush, h_clr;
  logic [1:0]  h_off;
  int          h_t, h_r;

  function automatic logic [31:0] m_status();
    int t = tx_q.size();
    int r = rx_q.size();
    logic [4:0] tc = t[4:0];
    logic [4:0] rc = r[4:0];
    return {11'b0, rc, 3'b0, tc, 2'b0, m_unf, m_ovf,
            (r == 0), (r == DEPTH), (t == 0), (t == DEPTH)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      m_ack = 1'b0;
      m_dat = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      h_hit = stb && cyc && (adr[31:4] == BASE_HI) && !m_ack;
      h_off = adr[3:2];
      h_t   = tx_q.size();
      h_r   = rx_q.size();
      m_dat = '0;
      if (h_hit && !we) begin
        if (h_off == 2'd1 && h_r > 0) m_dat = rx_q[0];
        if (h_off == 2'd2) m_dat = m_status();
      end
      h_flush = h_hit && we && h_off == 2'd3 && sel[0] && wdat[1];
      h_clr   = h_hit && we && h_off == 2'd3 && sel[0] && wdat[0];
      if (h_flush) begin
        tx_q.delete();
        rx_q.delete();
      end else begin
        if (h_t > 0 && mr) void'(tx_q.pop_front());
        if (h_hit && we && h_off == 2'd0) begin
          if (h_t < DEPTH) tx_q.push_back(wdat);
          else m_ovf = 1'b1;
        end
        if (h_hit && !we && h_off == 2'd1) begin
          if (h_r > 0) void'(rx_q.pop_front());
          else m_unf = 1'b1;
        end
        if (sv && h_r < DEPTH) rx_q.push_back(sd);
      end
      if (h_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      m_ack = h_hit;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("wbs_ack_o", {31'b0, ack}, {31'b0, m_ack});
    chk("wbs_dat_o", rdat, m_dat);
    chk("m_valid_o", {31'b0, mv}, {31'b0, tx_q.size() != 0});
    chk("s_ready_o", {31'b0, sr}, {31'b0, rx_q.size() < DEPTH});
    if (tx_q.size() != 0) chk("m_data_o", md, tx_q[0]);
  end

  // Random stream activity
  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      r_sv = $urandom_range(0, 1) == 1;
      r_sd = $urandom;
      r_mr = $urandom_range(0, 99) < mr_pct;
    end
  end

  task automatic wb_access(input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd_o, output logic acked);
    adr = a; we = w; wdat = d; sel = s;
    stb = 1'b1; cyc = 1'b1;
    acked = 1'b0; rd_o = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1'b1;
        rd_o  = rdat;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_wr(input logic [1:0] off, input logic [31:0] d,
                       input logic [3:0] s);
    logic [31:0] r;
    logic        a;
    wb_access(BASE | {28'b0, off, 2'b00}, 1'b1, d, s, r, a);
    chk("wr_ack", {31'b0, a}, 32'd1);
  endtask

  task automatic wb_rd(input logic [1:0] off, input logic [31:0] exp,
                       input string name);
    logic [31:0] r;
    logic        a;
    wb_access(BASE | {28'b0, off, 2'b00}, 1'b0, 32'h0, 4'hF, r, a);
    chk({name, "_ack"}, {31'b0, a}, 32'd1);
    chk(name, r, exp);
  endtask

  task automatic s_push(input logic [31:0] d);
    d_sv = 1'b1; d_sd = d;
    @(posedge clk); #1;
    d_sv = 1'b0;
  endtask

  logic [31:0] e3 [3] = '{32'h11, 32'h22, 32'h33};
  logic [31:0] rr;
  logic        ra, miss;
  logic [1:0]  roff;
  logic [31:0] raddr, rdata;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    wb_rd(2'd2, 32'h0000_000A, "status_reset");

    // TX fill with stalled consumer, then drain
    d_mr = 1'b0;
    for (int i = 0; i < 3; i++) wb_wr(2'd0, e3[i], 4'hF);
    wb_rd(2'd2, 32'h0000_0308, "status_tx3");
    d_mr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain3_valid", {31'b0, mv}, 32'd1);
      chk("drain3_data", md, e3[i]);
    end
    @(negedge clk);
    chk("drain3_empty", {31'b0, mv}, 32'd0);
    @(posedge clk); #1;
    d_mr = 1'b0;

    // TX overflow
    for (int i = 0; i < 9; i++) wb_wr(2'd0, 32'h1000 + i, 4'hF);
    wb_rd(2'd2, 32'h0000_0819, "status_tx_ovf");
    d_mr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ovf_drain", md, 32'h1000 + i);
    end
    @(negedge clk);
    chk("ovf_drain_empty", {31'b0, mv}, 32'd0);
    @(posedge clk); #1;
    d_mr = 1'b0;
    wb_wr(2'd3, 32'h1, 4'hF);
    wb_rd(2'd2, 32'h0000_000A, "status_clr1");

    // RX reads, underflow, CTRL byte-select
    s_push(32'hA5);
    s_push(32'h5A);
    wb_rd(2'd1, 32'hA5, "rx_first");
    wb_rd(2'd1, 32'h5A, "rx_second");
    wb_rd(2'd1, 32'h0, "rx_underflow");
    wb_rd(2'd2, 32'h0000_002A, "status_unf");
    wb_wr(2'd3, 32'h1, 4'hE);
    wb_rd(2'd2, 32'h0000_002A, "status_sel0_no_clr");
    wb_wr(2'd3, 32'h1, 4'hF);
    wb_rd(2'd2, 32'h0000_000A, "status_clr2");

    // RX full with a read racing a pending stream push
    for (int i = 0; i < 8; i++) begin
      d_sv = 1'b1; d_sd = 32'h100 + i;
      @(posedge clk); #1;
    end
    d_sd = 32'h200;
    wb_rd(2'd2, 32'h0008_0006, "status_rx_full");
    wb_rd(2'd1, 32'h100, "rx_pop_full");
    d_sv = 1'b0;
    wb_rd(2'd2, 32'h0008_0006, "status_rx_still8");
    for (int i = 1; i < 8; i++) wb_rd(2'd1, 32'h100 + i, "rx_order");
    wb_rd(2'd1, 32'h200, "rx_order_last");

    // Flush with a coincident stream push
    wb_wr(2'd0, 32'hA, 4'hF);
    wb_wr(2'd0, 32'hB, 4'hF);
    s_push(32'hC);
    s_push(32'hD);
    wb_rd(2'd2, 32'h0002_0200, "status_pre_flush");
    adr = BASE | 32'hC; we = 1'b1; wdat = 32'h2; sel = 4'h1;
    stb = 1'b1; cyc = 1'b1;
    d_sv = 1'b1; d_sd = 32'hDEAD;
    @(negedge clk);
    @(negedge clk);
    chk("flush_ack", {31'b0, ack}, 32'd1);
    chk("flush_tx_empty", {31'b0, mv}, 32'd0);
    chk("flush_rx_empty", {31'b0, sr}, 32'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; d_sv = 1'b0;
    @(posedge clk); #1;
    wb_rd(2'd2, 32'h0000_000A, "status_flush");

    // Reset with a request pending
    wb_wr(2'd0, 32'h77, 4'hF);
    s_push(32'h88);
    adr = BASE | 32'h8; we = 1'b0; sel = 4'hF;
    stb = 1'b1; cyc = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_m_valid", {31'b0, mv}, 32'd0);
    chk("rst_s_ready", {31'b0, sr}, 32'd1);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_ack_after_rst", {31'b0, ack}, 32'd0);
    end
    @(posedge clk); #1;
    wb_rd(2'd2, 32'h0000_000A, "status_after_rst");

    // Non-matching address
    wb_access(BASE + 32'h10, 1'b1, 32'h5, 4'hF, rr, ra);
    chk("miss_no_ack", {31'b0, ra}, 32'd0);
    wb_rd(2'd2, 32'h0000_000A, "status_after_miss");

    // Randomized traffic, model checks every cycle
    rand_en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) mr_pct = 80;
      miss  = $urandom_range(0, 15) == 0;
      roff  = 2'($urandom_range(0, 3));
      raddr = BASE | {28'b0, roff, 2'b00};
      if (miss) raddr = raddr ^ (32'h1 << $urandom_range(4, 31));
      rdata = $urandom;
      if (roff == 2'd3 && $urandom_range(0, 7) != 0) rdata[1] = 1'b0;
      wb_access(raddr, $urandom_range(0, 1) == 1, rdata,
                4'($urandom_range(0, 15)), rr, ra);
      if (!miss) chk("rand_ack", {31'b0, ra}, 32'd1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rand_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
